aes_enc_ctrl: RTL and testbench

Iterative AES-128 encryption controller. It accepts a plaintext block and a cipher key over a valid/ready handshake, then runs the initial AddRoundKey and rounds 1–10 through the existing combinational round stages (S-box substitution, row shift, mixColumns, AddRoundKey), one round per clock. It expands round keys on the fly and returns the ciphertext over a second valid/ready handshake. It sits between the bus/DMA front end and the round datapath, and is the only block that drives the datapath `round` input.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_enc_ctrl_if.sv | 24 ++
 rtl/aes_key_step.sv | 24 ++
 rtl/aes_round.sv | 43 ++++
 rtl/aes_enc_ctrl.sv | 102 ++++++++++
 tb/tb_aes_enc_ctrl.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block type, controller states, Rcon and S-box.
package aes_pkg;

    // Number of rounds for AES-128.
    localparam logic [3:0] NR = 4'd10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    // Round constant for rounds 1..10; zero outside that range.
    function automatic logic [7:0] get_rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Front-end handshake bundle: plaintext/key in, ciphertext out, status.
interface aes_enc_ctrl_if import aes_pkg::*; ();
    logic       in_valid;
    logic       in_ready;
    block_t     pt_in;
    block_t     key_in;
    logic       out_valid;
    logic       out_ready;
    block_t     ct_out;
    logic [3:0] round_o;
    logic       busy;

    // Front end / DMA side.
    modport master (
        output in_valid, pt_in, key_in, out_ready,
        input  in_ready, out_valid, ct_out, round_o, busy
    );

    // Encryption controller side.
    modport slave (
        input  in_valid, pt_in, key_in, out_ready,
        output in_ready, out_valid, ct_out, round_o, busy
    );
endinterface

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives the next round key.
module aes_key_step import aes_pkg::*; (
    input  block_t     key,
    input  logic [7:0] rcon,
    output block_t     key_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // SubWord(RotWord(w3)): rotate bytes left by one, then substitute.
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ t ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round.sv
// Combinational AES round stage: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// MixColumns is bypassed at round 0 and at the final round.
module aes_round import aes_pkg::*; (
    input  block_t     state_in,
    input  block_t     rk,
    input  logic [3:0] round,
    output block_t     state_out
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    block_t sb;
    block_t sr;
    block_t mc;

    // Byte i lives at [127-8i -: 8]; row = i % 4, column = i / 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        if (round == 4'd0 || round == NR)
            mc = sr;
    end

    assign state_out = mc ^ rk;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys
// expanded on the fly, valid/ready handshakes on both sides.
module aes_enc_ctrl import aes_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    aes_enc_ctrl_if.slave  bus
);

    fsm_t       fsm;
    fsm_t       fsm_next;
    block_t     state;
    block_t     rk;
    logic [3:0] round;

    block_t     rk_next;
    block_t     round_out;
    logic [7:0] rcon_cur;
    logic       load;
    logic       step;
    logic       handoff;

    assign rcon_cur = get_rcon(round);

    aes_key_step u_key_step (
        .key      (rk),
        .rcon     (rcon_cur),
        .key_next (rk_next)
    );

    aes_round u_round (
        .state_in  (state),
        .rk        (rk_next),
        .round     (round),
        .state_out (round_out)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        fsm_next      = fsm;
        load          = 1'b0;
        step          = 1'b0;
        handoff       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (fsm)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    load     = 1'b1;
                    fsm_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (round == NR) fsm_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    handoff  = 1'b1;
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Cipher state, round key and round counter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain registers, not memories, so all of them are
        // cleared by reset; an aborted block therefore never leaks to ct_out.
        if (rst) begin
            state <= '0;
            rk    <= '0;
            round <= 4'd0;
        end else if (load) begin
            state <= bus.pt_in ^ bus.key_in;
            rk    <= bus.key_in;
            round <= 4'd1;
        end else if (step) begin
            state <= round_out;
            rk    <= rk_next;
            if (round != NR) round <= round + 4'd1;
        end else if (handoff) begin
            round <= 4'd0;
        end
    end

    assign bus.ct_out  = state;
    assign bus.round_o = round;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl using FIPS-197 and known-answer vectors.
module tb_aes_enc_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;

    aes_enc_ctrl_if bus ();

    aes_enc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string  name;
        block_t key;
        block_t pt;
        block_t ct;
        bit     scramble;
    } vec_t;

    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic block_t rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Accept one block, step through all rounds, check ciphertext and
    // optionally complete the output handshake. Starts and ends just after
    // a falling edge.
    task automatic run_block(input vec_t v, input bit do_handoff);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({v.name, " ready_before_accept"}, 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.pt_in    = v.pt;
        bus.key_in   = v.key;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({v.name, " in_ready_after_accept"}, 128'(bus.in_ready), 128'd0);
        check({v.name, " round_1"}, 128'(bus.round_o), 128'd1);
        for (int k = 1; k <= 9; k++) begin
            if (v.scramble) begin
                bus.pt_in  = rand_block();
                bus.key_in = rand_block();
            end
            @(negedge clk);
            check($sformatf("%s round_%0d", v.name, k + 1), 128'(bus.round_o), 128'(k + 1));
            check($sformatf("%s out_valid_low_%0d", v.name, k), 128'(bus.out_valid), 128'd0);
        end
        @(negedge clk);
        check({v.name, " out_valid_after_E10"}, 128'(bus.out_valid), 128'd1);
        check({v.name, " round_done"}, 128'(bus.round_o), 128'd10);
        check({v.name, " ct"}, bus.ct_out, v.ct);
        if (do_handoff) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({v.name, " idle_in_ready"}, 128'(bus.in_ready), 128'd1);
            check({v.name, " idle_out_valid"}, 128'(bus.out_valid), 128'd0);
            check({v.name, " idle_round"}, 128'(bus.round_o), 128'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        int   cyc;
        int   n_acc;
        int   n_out;
        int   acc_cyc[4];
        logic prev_ready;

        vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
        vecs[2] = '{"zero_scr", 128'h0, 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1};
        vecs[3] = '{"appb_scr", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pt_in     = '0;
        bus.key_in    = '0;
        @(negedge clk);
        check("reset in_ready", 128'(bus.in_ready), 128'd1);
        check("reset out_valid", 128'(bus.out_valid), 128'd0);
        check("reset busy", 128'(bus.busy), 128'd0);
        check("reset ct_out", bus.ct_out, 128'd0);
        check("reset round_o", 128'(bus.round_o), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of known-answer vectors, some with inputs scrambled after accept.
        for (int i = 0; i < 4; i++)
            run_block(vecs[i], 1'b1);

        // Backpressure: hold DONE for 20 cycles while in_valid pulses.
        run_block(vecs[0], 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i % 3 == 0);
            bus.pt_in    = rand_block();
            bus.key_in   = rand_block();
            @(negedge clk);
            check($sformatf("bp ct_stable_%0d", i), bus.ct_out, vecs[0].ct);
            check($sformatf("bp in_ready_%0d", i), 128'(bus.in_ready), 128'd0);
            check($sformatf("bp out_valid_%0d", i), 128'(bus.out_valid), 128'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp release in_ready", 128'(bus.in_ready), 128'd1);
        check("bp release busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        check("bp nothing_queued", 128'(bus.busy), 128'd0);

        // Reset in the middle of a block.
        bus.in_valid = 1'b1;
        bus.pt_in    = vecs[0].pt;
        bus.key_in   = vecs[0].key;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round_o !== 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst reached round 5", 128'(bus.round_o), 128'd5);
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", 128'(bus.out_valid), 128'd0);
        check("midrst in_ready", 128'(bus.in_ready), 128'd1);
        check("midrst ct_out", bus.ct_out, 128'd0);
        check("midrst round_o", 128'(bus.round_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(vecs[0], 1'b1);

        // Back-to-back: in_valid and out_ready held high, vectors alternate.
        foreach (acc_cyc[i]) acc_cyc[i] = 0;
        cyc   = 0;
        n_acc = 0;
        n_out = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.pt_in     = vecs[0].pt;
        bus.key_in    = vecs[0].key;
        prev_ready    = bus.in_ready;
        while (n_out < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (prev_ready) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.pt_in  = vecs[n_acc % 2].pt;
                bus.key_in = vecs[n_acc % 2].key;
            end
            if (bus.out_valid) begin
                check($sformatf("b2b ct_%0d", n_out), bus.ct_out, vecs[n_out % 2].ct);
                n_out++;
            end
            prev_ready = bus.in_ready;
        end
        check("b2b outputs seen", 128'(n_out), 128'd3);
        check("b2b period_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
        check("b2b period_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd12);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b final idle", 128'(bus.in_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
